// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator controller and its arithmetic unit.
package calc_pkg;

    typedef enum logic [1:0] {
        ENTER_A,
        ENTER_B,
        COMPUTE,
        DONE
    } state_t;

    typedef logic [3:0] op_t;

    localparam op_t OP_ADD = 4'b0001;
    localparam op_t OP_SUB = 4'b0010;
    localparam op_t OP_MUL = 4'b0100;
    localparam op_t OP_DIV = 4'b1000;

    localparam int unsigned RADIX = 10;

endpackage

// File: rtl/calc_seq_muldiv.sv
// Iterative signed multiply (shift-add) and divide (restoring), one bit per cycle on magnitudes.
module calc_seq_muldiv #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic                 run_q, div_q, neg_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       rem_sh, trial;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;

    assign mag_a = a_i[WIDTH-1] ? -a_i : a_i;
    assign mag_b = b_i[WIDTH-1] ? -b_i : b_i;

    // Divide: acc holds the partial remainder, y shifts the dividend out and the quotient in.
    assign rem_sh = {acc_q[WIDTH-1:0], y_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, x_q[WIDTH-1:0]};

    always_comb begin
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
        if (div_q) begin
            if (!trial[WIDTH]) begin
                acc_d = {{(WIDTH-1){1'b0}}, trial};
                y_d   = {y_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {{(WIDTH-1){1'b0}}, rem_sh};
                y_d   = {y_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = y_q[0] ? acc_q + x_q : acc_q;
            x_d   = {x_q[2*WIDTH-2:0], 1'b0};
            y_d   = {1'b0, y_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || abort_i) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            div_q <= div_i;
            neg_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            cnt_q <= CW'(WIDTH);
            acc_q <= '0;
            x_q   <= {{WIDTH{1'b0}}, (div_i ? mag_b : mag_a)};
            y_q   <= div_i ? mag_a : mag_b;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
                acc_q <= acc_d;
                x_q   <= x_d;
                y_q   <= y_d;
            end else begin
                run_q <= 1'b0;
            end
        end
    end

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -y_q : y_q;

    assign done_o   = run_q && (cnt_q == '0);
    assign result_o = div_q ? quo : prod[WIDTH-1:0];
    // Only MIN / -1 produces a positive quotient that does not fit.
    assign ovf_o    = div_q ? (!neg_q && y_q[WIDTH-1])
                            : !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

endmodule

// File: rtl/calc_ctrl.sv
// Keypad calculator controller: operand entry, operator sequencing and result/flag reporting.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [3:0]       keypad_input,
    input  logic             read_input,
    input  logic             neg_input,
    input  logic [3:0]       operator_input,
    input  logic             equal_input,
    input  logic             clear_input,
    output logic [WIDTH-1:0] display_output,
    output logic             complete,
    output logic             busy,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int unsigned     EW     = WIDTH + 4;
    localparam int unsigned     DW     = $clog2(MAX_DIGITS + 1);
    localparam logic [DW-1:0]   MaxDig = DW'(MAX_DIGITS);
    localparam logic [EW-1:0]   MaxMag = (EW'(1) << (WIDTH - 1)) - EW'(1);

    state_t           state_q;
    op_t              op_q, op_prev_q;
    logic [WIDTH-1:0] a_q, cur_q;
    logic [DW-1:0]    digits_q;
    logic             neg_q, b_seen_q, ovf_q, dbz_q;
    logic             rd_prev_q, neg_prev_q, eq_prev_q, clr_prev_q;

    logic             rd_e, neg_e, eq_e, clr_e, op_ok;
    logic [WIDTH-1:0] mag, app_w, digit_val, neg_cur, sum, diff, as_res;
    logic [EW-1:0]    appended;
    logic             digit_ok, is_as, as_ovf;
    logic             md_start, md_done, md_ovf;
    logic [WIDTH-1:0] md_res;

    assign rd_e  = read_input && !rd_prev_q && (keypad_input <= 4'd9);
    assign neg_e = neg_input && !neg_prev_q;
    assign eq_e  = equal_input && !eq_prev_q;
    assign clr_e = clear_input && !clr_prev_q;
    assign op_ok = (|(operator_input & ~op_prev_q)) &&
                   (operator_input inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV});

    // Operands are built on the magnitude; the sign flag is reapplied after each digit.
    assign mag       = neg_q ? -cur_q : cur_q;
    assign appended  = EW'(mag) * EW'(RADIX) + EW'(keypad_input);
    assign app_w     = appended[WIDTH-1:0];
    assign digit_ok  = (digits_q < MaxDig) && (appended <= MaxMag);
    assign digit_val = neg_q ? -app_w : app_w;
    assign neg_cur   = -cur_q;

    assign sum    = a_q + cur_q;
    assign diff   = a_q - cur_q;
    assign is_as  = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign as_res = (op_q == OP_ADD) ? sum : diff;
    assign as_ovf = (op_q == OP_ADD)
                  ? ((a_q[WIDTH-1] == cur_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]))
                  : ((a_q[WIDTH-1] != cur_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]));

    assign md_start = !clr_e && eq_e && (state_q == ENTER_B) &&
                      ((op_q == OP_MUL) || ((op_q == OP_DIV) && (cur_q != '0)));

    calc_seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk_i    (clk),
        .rst_ni   (nRST),
        .start_i  (md_start),
        .abort_i  (clr_e),
        .div_i    (op_q == OP_DIV),
        .a_i      (a_q),
        .b_i      (cur_q),
        .done_o   (md_done),
        .result_o (md_res),
        .ovf_o    (md_ovf)
    );

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q    <= ENTER_A;
            op_q       <= OP_ADD;
            a_q        <= '0;
            cur_q      <= '0;
            digits_q   <= '0;
            neg_q      <= 1'b0;
            b_seen_q   <= 1'b0;
            ovf_q      <= 1'b0;
            dbz_q      <= 1'b0;
            op_prev_q  <= '0;
            rd_prev_q  <= 1'b0;
            neg_prev_q <= 1'b0;
            eq_prev_q  <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            op_prev_q  <= operator_input;
            rd_prev_q  <= read_input;
            neg_prev_q <= neg_input;
            eq_prev_q  <= equal_input;
            clr_prev_q <= clear_input;
            if (clr_e) begin
                state_q  <= ENTER_A;
                op_q     <= OP_ADD;
                a_q      <= '0;
                cur_q    <= '0;
                digits_q <= '0;
                neg_q    <= 1'b0;
                b_seen_q <= 1'b0;
                ovf_q    <= 1'b0;
                dbz_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    ENTER_A: begin
                        if (eq_e) begin
                            state_q <= DONE;
                            ovf_q   <= 1'b0;
                            dbz_q   <= 1'b0;
                        end else if (op_ok) begin
                            state_q  <= ENTER_B;
                            op_q     <= operator_input;
                            a_q      <= cur_q;
                            cur_q    <= '0;
                            neg_q    <= 1'b0;
                            digits_q <= '0;
                            b_seen_q <= 1'b0;
                        end else if (rd_e) begin
                            if (digit_ok) begin
                                cur_q    <= digit_val;
                                digits_q <= digits_q + 1'b1;
                            end
                        end else if (neg_e) begin
                            cur_q <= neg_cur;
                            neg_q <= !neg_q;
                        end
                    end
                    ENTER_B: begin
                        if (eq_e) begin
                            ovf_q <= 1'b0;
                            if ((op_q == OP_DIV) && (cur_q == '0)) begin
                                state_q <= DONE;
                                dbz_q   <= 1'b1;
                            end else begin
                                state_q <= COMPUTE;
                                dbz_q   <= 1'b0;
                            end
                        end else if (op_ok && !b_seen_q) begin
                            op_q <= operator_input;
                        end else if (rd_e) begin
                            if (digit_ok) begin
                                cur_q    <= digit_val;
                                digits_q <= digits_q + 1'b1;
                                b_seen_q <= 1'b1;
                            end
                        end else if (neg_e) begin
                            cur_q <= neg_cur;
                            neg_q <= !neg_q;
                        end
                    end
                    COMPUTE: begin
                        if (is_as) begin
                            state_q <= DONE;
                            cur_q   <= as_res;
                            ovf_q   <= as_ovf;
                        end else if (md_done) begin
                            state_q <= DONE;
                            cur_q   <= md_res;
                            ovf_q   <= md_ovf;
                        end
                    end
                    DONE: begin
                        if (op_ok) begin
                            state_q  <= ENTER_B;
                            op_q     <= operator_input;
                            a_q      <= cur_q;
                            cur_q    <= '0;
                            neg_q    <= 1'b0;
                            digits_q <= '0;
                            b_seen_q <= 1'b0;
                        end else if (rd_e) begin
                            state_q  <= ENTER_A;
                            cur_q    <= WIDTH'(keypad_input);
                            neg_q    <= 1'b0;
                            digits_q <= DW'(1);
                        end else if (neg_e) begin
                            state_q  <= ENTER_A;
                            cur_q    <= neg_cur;
                            neg_q    <= neg_cur[WIDTH-1];
                            digits_q <= '0;
                        end
                    end
                    default: state_q <= ENTER_A;
                endcase
            end
        end
    end

    assign display_output = cur_q;
    assign complete       = (state_q == DONE);
    assign busy           = (state_q == COMPUTE);
    assign overflow       = ovf_q;
    assign div_by_zero    = dbz_q;

endmodule
